// File: rtl/cpu_alu_pkg.sv
// Shared op encoding, FSM state type and op classification for the multicycle ALU.
package cpu_alu_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_SIGNED_ADD   = 4'd0;
  localparam logic [OP_W-1:0] OP_UNSIGNED_ADD = 4'd1;
  localparam logic [OP_W-1:0] OP_SUB          = 4'd2;
  localparam logic [OP_W-1:0] OP_AND          = 4'd3;
  localparam logic [OP_W-1:0] OP_OR           = 4'd4;
  localparam logic [OP_W-1:0] OP_XOR          = 4'd5;
  localparam logic [OP_W-1:0] OP_SLL          = 4'd6;
  localparam logic [OP_W-1:0] OP_SRL          = 4'd7;
  localparam logic [OP_W-1:0] OP_SRA          = 4'd8;
  localparam logic [OP_W-1:0] OP_SLT          = 4'd9;
  localparam logic [OP_W-1:0] OP_SLTU         = 4'd10;
  localparam logic [OP_W-1:0] OP_SGE          = 4'd11;
  localparam logic [OP_W-1:0] OP_SGEU         = 4'd12;
  localparam logic [OP_W-1:0] OP_EQ           = 4'd13;
  localparam logic [OP_W-1:0] OP_NE           = 4'd14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_e;

  function automatic logic is_shift_op(input logic [OP_W-1:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/cpu_alu_multicycle_shift_step.sv
// One iteration of the iterative shifter: shifts by 0..SHIFT_STEP positions.
module cpu_alu_shift_step
  import cpu_alu_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SHIFT_STEP = 4,
  parameter int unsigned AMT_W      = $clog2(SHIFT_STEP + 1)
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             dir_left_i,
  input  logic             arith_i,
  input  logic [AMT_W-1:0] amount_i,
  output logic [WIDTH-1:0] value_o
);

  always_comb begin
    value_o = value_i;
    if (dir_left_i) begin
      value_o = value_i << amount_i;
    end else if (arith_i) begin
      value_o = $signed(value_i) >>> amount_i;
    end else begin
      value_o = value_i >> amount_i;
    end
  end

endmodule

// File: rtl/cpu_alu_multicycle.sv
// Handshaked execute-stage ALU: single-cycle arithmetic/logic/compare, iterative shifts.
module cpu_alu_multicycle
  import cpu_alu_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SHIFT_STEP = 4
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [OP_W-1:0]  i_op,
  input  logic [WIDTH-1:0] i_op1,
  input  logic [WIDTH-1:0] i_op2,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_compare_result,
  output logic             o_busy
);

  localparam int unsigned SH_W  = $clog2(WIDTH);
  localparam int unsigned AMT_W = $clog2(SHIFT_STEP + 1);

  alu_state_e       state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SH_W-1:0]  rem_q, rem_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cmp_q, cmp_d;

  logic             accept;
  logic [SH_W-1:0]  in_amt;
  logic             in_shift;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cmp;
  logic [AMT_W-1:0] step_amt;
  logic [SH_W-1:0]  rem_next;
  logic [WIDTH-1:0] step_out;

  // A pending flush or reset blocks acceptance; DONE frees up as soon as its result is taken.
  assign o_ready  = !i_reset && !i_flush &&
                    ((state_q == IDLE) || ((state_q == DONE) && i_ready));
  assign accept   = i_valid && o_ready;
  assign in_amt   = i_op2[SH_W-1:0];
  assign in_shift = is_shift_op(i_op);

  // Single-cycle datapath; zero-amount shifts pass op1 straight through.
  always_comb begin
    alu_res = '0;
    alu_cmp = 1'b0;
    case (i_op)
      OP_SIGNED_ADD,
      OP_UNSIGNED_ADD: alu_res = i_op1 + i_op2;
      OP_SUB:          alu_res = i_op1 - i_op2;
      OP_AND:          alu_res = i_op1 & i_op2;
      OP_OR:           alu_res = i_op1 | i_op2;
      OP_XOR:          alu_res = i_op1 ^ i_op2;
      OP_SLL,
      OP_SRL,
      OP_SRA:          alu_res = i_op1;
      OP_SLT:          alu_cmp = $signed(i_op1) < $signed(i_op2);
      OP_SLTU:         alu_cmp = i_op1 < i_op2;
      OP_SGE:          alu_cmp = $signed(i_op1) >= $signed(i_op2);
      OP_SGEU:         alu_cmp = i_op1 >= i_op2;
      OP_EQ:           alu_cmp = i_op1 == i_op2;
      OP_NE:           alu_cmp = i_op1 != i_op2;
      default: begin
        alu_res = '0;
        alu_cmp = 1'b0;
      end
    endcase
  end

  // Step size is min(remaining, SHIFT_STEP); remaining never exceeds WIDTH-1.
  always_comb begin
    if (32'(rem_q) < SHIFT_STEP) begin
      step_amt = AMT_W'(rem_q);
    end else begin
      step_amt = AMT_W'(SHIFT_STEP);
    end
  end

  assign rem_next = rem_q - SH_W'(step_amt);

  cpu_alu_shift_step #(
    .WIDTH      (WIDTH),
    .SHIFT_STEP (SHIFT_STEP),
    .AMT_W      (AMT_W)
  ) u_shift_step (
    .value_i    (acc_q),
    .dir_left_i (op_q == OP_SLL),
    .arith_i    (op_q == OP_SRA),
    .amount_i   (step_amt),
    .value_o    (step_out)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    result_d = result_q;
    cmp_d    = cmp_q;

    if (i_flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if ((state_q == DONE) && i_ready) begin
            state_d = IDLE;
          end
          if (accept) begin
            if (in_shift && (in_amt != '0)) begin
              state_d = SHIFT;
              op_d    = i_op;
              acc_d   = i_op1;
              rem_d   = in_amt;
            end else begin
              state_d  = DONE;
              result_d = alu_res;
              cmp_d    = alu_cmp;
            end
          end
        end
        SHIFT: begin
          acc_d = step_out;
          rem_d = rem_next;
          if (rem_next == '0) begin
            state_d  = DONE;
            result_d = step_out;
            cmp_d    = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
      cmp_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      cmp_q    <= cmp_d;
    end
  end

  assign o_valid          = (state_q == DONE);
  assign o_busy           = (state_q == SHIFT);
  assign o_result         = result_q;
  assign o_compare_result = cmp_q;

endmodule
